// File: rtl/proc_pkg.sv
// ============================================================================
// Module   : proc_pkg
// Brief    : Shared types and constants for the instruction fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_REL  = 2'b01,
        PC_JALR = 2'b10
    } pc_sel_t;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        TRAP  = 2'b11
    } fetch_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// Module   : next_pc_calc
// Brief    : Combinational next-PC selection for seq / PC-relative / JALR flow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_calc
    import proc_pkg::*;
(
    input  logic [63:0] Pc,
    input  logic [63:0] Imm,
    input  logic [63:0] Rs1,
    input  logic [1:0]  PcSel,
    output logic [63:0] NextPc,
    output logic        Misaligned
);

    logic [63:0] w_seq;
    logic [63:0] w_rel;
    logic [63:0] w_jalr;

    assign w_seq  = Pc + 64'd4;
    assign w_rel  = Pc + Imm;
    assign w_jalr = Rs1 + Imm;

    // Encoding 11 is not a legal select and falls back to sequential flow.
    always_comb begin
        NextPc = w_seq;
        case (PcSel)
            PC_REL:  NextPc = w_rel;
            PC_JALR: NextPc = {w_jalr[63:1], 1'b0};
            default: NextPc = w_seq;
        endcase
    end

    assign Misaligned = |NextPc[1:0];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : Multi-cycle fetch front end: PC, instruction register, fetch FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit
    import proc_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Inst,
    output logic        InstValid,
    input  logic [63:0] Imm,
    input  logic [63:0] Rs1,
    input  logic [1:0]  PcSel,
    input  logic        Advance,
    output logic [63:0] Pc,
    output logic [63:0] PcPlus4,
    output logic [1:0]  ErrCode
);

    localparam int                c_CNT_W    = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    fetch_state_t       r_state,      w_state;
    logic [63:0]        r_pc,         w_pc;
    logic [31:0]        r_inst,       w_inst;
    logic               r_inst_valid, w_inst_valid;
    logic               r_req,        w_req;
    err_t               r_err,        w_err;
    logic [c_CNT_W-1:0] r_cnt,        w_cnt;

    logic [63:0]        w_next_pc;
    logic               w_misaligned;

    next_pc_calc u_next_pc_calc (
        .Pc         (r_pc),
        .Imm        (Imm),
        .Rs1        (Rs1),
        .PcSel      (PcSel),
        .NextPc     (w_next_pc),
        .Misaligned (w_misaligned)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
            r_req        <= 1'b0;
            r_err        <= ERR_NONE;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_inst       <= w_inst;
            r_inst_valid <= w_inst_valid;
            r_req        <= w_req;
            r_err        <= w_err;
            r_cnt        <= w_cnt;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_inst       = r_inst;
        w_inst_valid = r_inst_valid;
        w_req        = r_req;
        w_err        = r_err;
        w_cnt        = r_cnt;
        case (r_state)
            // Request is registered, so it first appears one clock after BOOT.
            BOOT: begin
                w_state = FETCH;
                w_req   = 1'b1;
            end
            FETCH: begin
                if (ImemAck) begin
                    w_inst       = ImemData;
                    w_inst_valid = 1'b1;
                    w_req        = 1'b0;
                    w_cnt        = '0;
                    w_state      = HOLD;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_req        = 1'b0;
                    w_err        = ERR_TIMEOUT;
                    w_inst       = NOP_INST;
                    w_inst_valid = 1'b0;
                    w_cnt        = '0;
                    w_state      = TRAP;
                end else begin
                    w_cnt = r_cnt + c_CNT_W'(1);
                end
            end
            HOLD: begin
                if (Advance) begin
                    w_inst_valid = 1'b0;
                    if (w_misaligned) begin
                        w_err   = ERR_MISALIGN;
                        w_inst  = NOP_INST;
                        w_state = TRAP;
                    end else begin
                        w_pc    = w_next_pc;
                        w_req   = 1'b1;
                        w_state = FETCH;
                    end
                end
            end
            default: begin
                w_state = TRAP;
            end
        endcase
    end

    assign ImemReq   = r_req;
    assign ImemAddr  = r_pc;
    assign Inst      = r_inst;
    assign InstValid = r_inst_valid;
    assign Pc        = r_pc;
    assign PcPlus4   = r_pc + 64'd4;
    assign ErrCode   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module   : tb_inst_fetch_unit
// Brief    : Scoreboard bench for inst_fetch_unit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_unit;
    import proc_pkg::*;

    localparam logic [63:0] c_RESET_PC = 64'h1000;
    localparam int          c_TIMEOUT  = 4;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b1;
    logic        ImemAck  = 1'b0;
    logic [31:0] ImemData = '0;
    logic [63:0] Imm      = '0;
    logic [63:0] Rs1      = '0;
    logic [1:0]  PcSel    = '0;
    logic        Advance  = 1'b0;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic [31:0] Inst;
    logic        InstValid;
    logic [63:0] Pc;
    logic [63:0] PcPlus4;
    logic [1:0]  ErrCode;

    inst_fetch_unit #(
        .RESET_PC (c_RESET_PC),
        .TIMEOUT  (c_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemAck   (ImemAck),
        .ImemData  (ImemData),
        .Inst      (Inst),
        .InstValid (InstValid),
        .Imm       (Imm),
        .Rs1       (Rs1),
        .PcSel     (PcSel),
        .Advance   (Advance),
        .Pc        (Pc),
        .PcPlus4   (PcPlus4),
        .ErrCode   (ErrCode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_fetch_q[$];
    logic [31:0] exp_inst_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every new fetch request and every newly valid instruction is
    // matched against the next entry the stimulus queued.
    logic mon_prev_req   = 1'b0;
    logic mon_prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_prev_req   <= 1'b0;
            mon_prev_valid <= 1'b0;
        end else begin
            if (ImemReq && !mon_prev_req) begin
                if (exp_fetch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_addr: unexpected request at %0h, required none", ImemAddr);
                end else begin
                    chk("fetch_addr", ImemAddr, exp_fetch_q.pop_front());
                end
            end
            if (InstValid && !mon_prev_valid) begin
                if (exp_inst_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst_word: unexpected valid Inst %0h, required none", Inst);
                end else begin
                    chk("inst_word", 64'(Inst), 64'(exp_inst_q.pop_front()));
                end
            end
            mon_prev_req   <= ImemReq;
            mon_prev_valid <= InstValid;
        end
    end

    task automatic do_reset(input logic boot_ack, input logic [31:0] data);
        reset_n  = 1'b0;
        Advance  = 1'b0;
        ImemAck  = boot_ack;
        ImemData = data;
        repeat (2) @(negedge clk);
        chk("rst_pc",    Pc,               c_RESET_PC);
        chk("rst_inst",  64'(Inst),        64'(NOP_INST));
        chk("rst_valid", 64'(InstValid),   64'd0);
        chk("rst_req",   64'(ImemReq),     64'd0);
        chk("rst_err",   64'(ErrCode),     64'(ERR_NONE));
        reset_n = 1'b1;
        exp_fetch_q.push_back(c_RESET_PC);
        #1;
        chk("boot_req", 64'(ImemReq), 64'd0);
        @(negedge clk);
        ImemAck = 1'b0;
        chk("boot_inst",  64'(Inst),      64'(NOP_INST));
        chk("boot_valid", 64'(InstValid), 64'd0);
        chk("boot_req2",  64'(ImemReq),   64'd1);
    endtask

    task automatic fetch(input logic [31:0] data, input int lat);
        int n = 0;
        while (!ImemReq && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!ImemReq) begin
            checks++;
            errors++;
            $display("FAIL fetch_wait: ImemReq 0 after %0d cycles, required 1", n);
            return;
        end
        repeat (lat) @(negedge clk);
        ImemAck  = 1'b1;
        ImemData = data;
        exp_inst_q.push_back(data);
        @(negedge clk);
        ImemAck = 1'b0;
    endtask

    task automatic advance(input logic [1:0] sel, input logic [63:0] imm,
                           input logic [63:0] rs1, input logic [63:0] exp_pc,
                           input logic exp_trap);
        PcSel   = sel;
        Imm     = imm;
        Rs1     = rs1;
        Advance = 1'b1;
        if (!exp_trap) exp_fetch_q.push_back(exp_pc);
        @(negedge clk);
        Advance = 1'b0;
        chk("adv_pc",    Pc,             exp_pc);
        chk("adv_valid", 64'(InstValid), 64'd0);
        if (exp_trap) begin
            chk("trap_err",  64'(ErrCode), 64'(ERR_MISALIGN));
            chk("trap_req",  64'(ImemReq), 64'd0);
            chk("trap_inst", 64'(Inst),    64'(NOP_INST));
        end else begin
            chk("adv_req", 64'(ImemReq), 64'd1);
            chk("adv_err", 64'(ErrCode), 64'(ERR_NONE));
        end
    endtask

    initial begin
        int n;
        #1;
        // Boot with a stray ack held through reset and BOOT
        do_reset(1'b1, 32'hDEADBEEF);
        fetch(32'h00500093, 0);
        chk("first_pc",  Pc,      64'h1000);
        chk("first_pc4", PcPlus4, 64'h1004);

        advance(PC_SEQ, 64'h0, 64'h0, 64'h1004, 1'b0);
        fetch(32'h00108113, 2);
        advance(PC_REL, 64'hC, 64'h0, 64'h1010, 1'b0);
        fetch(32'hFE000CE3, 1);
        advance(PC_REL, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h1008, 1'b0);
        fetch(32'h123450EF, 0);
        advance(2'b11, 64'h40, 64'h0, 64'h100C, 1'b0);
        fetch(32'h00000463, 1);
        advance(PC_JALR, 64'h4, 64'h2001, 64'h2004, 1'b0);
        fetch(32'h000080E7, 0);
        // JALR sum wraps past 2^64 and lands on 0x1 -> bit0 cleared -> 0x0
        advance(PC_JALR, 64'h11, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 1'b0);
        chk("wrap_pc4", PcPlus4, 64'h4);

        // Advance while FETCH is still waiting must not move the PC
        PcSel   = PC_REL;
        Imm     = 64'h100;
        Advance = 1'b1;
        @(negedge clk);
        Advance = 1'b0;
        chk("fetch_adv_pc",  Pc,           64'h0);
        chk("fetch_adv_req", 64'(ImemReq), 64'd1);
        fetch(32'h00C00593, 0);

        advance(PC_REL, 64'h1000, 64'h0, 64'h1000, 1'b0);
        fetch(32'h00A00513, 0);

        // Ack in HOLD is ignored
        ImemAck  = 1'b1;
        ImemData = 32'hBAD0BAD0;
        @(negedge clk);
        ImemAck = 1'b0;
        chk("hold_ack_inst",  64'(Inst),      64'h00A00513);
        chk("hold_ack_valid", 64'(InstValid), 64'd1);
        chk("hold_ack_req",   64'(ImemReq),   64'd0);

        // Misaligned PC-relative target traps and keeps Pc
        advance(PC_REL, 64'h2, 64'h0, 64'h1000, 1'b1);
        PcSel    = PC_SEQ;
        Advance  = 1'b1;
        ImemAck  = 1'b1;
        ImemData = 32'h11111111;
        repeat (3) @(negedge clk);
        Advance = 1'b0;
        ImemAck = 1'b0;
        chk("trap_hold_pc",    Pc,             64'h1000);
        chk("trap_hold_err",   64'(ErrCode),   64'(ERR_MISALIGN));
        chk("trap_hold_req",   64'(ImemReq),   64'd0);
        chk("trap_hold_valid", 64'(InstValid), 64'd0);
        chk("trap_hold_inst",  64'(Inst),      64'(NOP_INST));

        // Fetch timeout: request stays up for exactly TIMEOUT cycles
        do_reset(1'b0, 32'h0);
        n = 0;
        while (ImemReq && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_cycles", 64'(n),          64'(c_TIMEOUT));
        chk("timeout_err",    64'(ErrCode),    64'(ERR_TIMEOUT));
        chk("timeout_req",    64'(ImemReq),    64'd0);
        chk("timeout_valid",  64'(InstValid),  64'd0);

        // Asynchronous reset in the middle of a fetch, late ack during BOOT
        do_reset(1'b0, 32'h0);
        fetch(32'h00000513, 1);
        advance(PC_SEQ, 64'h0, 64'h0, 64'h1004, 1'b0);
        ImemData = 32'hCAFEF00D;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        ImemAck = 1'b1;
        #1;
        chk("async_req",   64'(ImemReq),   64'd0);
        chk("async_pc",    Pc,             c_RESET_PC);
        chk("async_addr",  ImemAddr,       c_RESET_PC);
        chk("async_valid", 64'(InstValid), 64'd0);
        chk("async_inst",  64'(Inst),      64'(NOP_INST));
        do_reset(1'b1, 32'hCAFEF00D);
        fetch(32'h00100073, 0);
        chk("final_pc", Pc, c_RESET_PC);

        @(negedge clk);
        chk("fetch_q_empty", 64'(exp_fetch_q.size()), 64'd0);
        chk("inst_q_empty",  64'(exp_inst_q.size()),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
